jedro_1_data_ram: RTL and testbench
===================================

Name: jedro_1_data_ram

Overview:
- Responder (slave) end of the core's data-memory read/write port.
- Accepts word-aligned load/store requests from the core's data master.
- Stores data in an internal word array with per-byte write enables.
- Returns responses after a configurable number of wait states.
- Used as on-chip data RAM in simulation and FPGA builds, sitting opposite the core top on the data bus.

Parameters:
- DATA_WIDTH, 32, data and address bus width in bits.
- MEM_WORDS, 1024, number of storage words; must be a power of two.
- WAIT_STATES, 0, extra cycles between request acceptance and response (0..15).
- MEM_INIT_FILE, "", hex file loaded with $readmemh at time zero; no load if empty.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid from the core.
- we_i  in  4  byte write enables; 4'b0000 means a read.
- addr_i  in  DATA_WIDTH  byte address; bits [1:0] ignored.
- wdata_i  in  DATA_WIDTH  store data; byte n is bits [8n+7:8n].
- gnt_co  out  1  combinational grant; request accepted when req_i && gnt_co at the clock edge.
- rvalid_ro  out  1  registered one-cycle response pulse, for both reads and writes.
- rdata_ro  out  DATA_WIDTH  registered load data.
- err_ro  out  1  registered error flag, valid with rvalid_ro.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous and active-low.
- Reset values:
  - State = IDLE, wait counter = 0.
  - rvalid_ro = 0, rdata_ro = 0, err_ro = 0.
  - Memory array is not cleared by reset.
- Word index: idx = addr_i[2 +: $clog2(MEM_WORDS)].
- Accepted request: addr, we and wdata are latched into request registers.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - gnt_co = 1.
    - On accept: go to RESP if WAIT_STATES == 0; otherwise load counter with WAIT_STATES and go to WAIT.
  - WAIT:
    - gnt_co = 0; counter decrements every cycle.
    - When the counter reaches 1, go to RESP on the next edge.
  - RESP:
    - rvalid_ro = 1 for exactly this cycle.
    - gnt_co = 1; a request accepted here follows the same rules as in IDLE (back-to-back).
    - No accept: return to IDLE.
- Commit point: the array access happens on the edge that enters RESP.
  - Write: each byte n with we[n] = 1 is updated from wdata; other bytes are kept.
  - Read: rdata_ro <= mem[idx].
  - For writes, rdata_ro holds its previous value.
- Latency: rvalid_ro rises exactly WAIT_STATES + 1 cycles after the accepting edge.
- Throughput: 1 transaction every WAIT_STATES + 1 cycles. With WAIT_STATES = 0, one transaction per cycle.
- Read-after-write: a read accepted on or after the edge that commits a write returns the written data.
- req_i while gnt_co = 0: ignored. The master must hold the request; it is not queued.
- Reset mid-operation: an uncommitted transaction is dropped (no array write, no rvalid_ro). The FSM returns to IDLE.
- Address wrap: addresses beyond MEM_WORDS*4 wrap modulo the array size, unless the optional feature is enabled.

Optional Feature:
- Macro: JEDRO_1_DATA_RAM_ERR_EN.
- Defined: a request with addr_i >= MEM_WORDS*4 is flagged out-of-range at acceptance. At its response:
  - err_ro = 1 together with rvalid_ro.
  - No array write.
  - rdata_ro = 0.
  - err_ro returns to 0 on the next cycle.
- Not defined: err_ro tied to 0 and addresses wrap as above.

Test Plan:
- Write then read, WAIT_STATES = 0:
  - Stimulus: write we = 4'hF, addr = 0x10, wdata = 0xDEADBEEF; on the next cycle, read addr = 0x10.
  - Response: rvalid_ro on cycles +1 and +2; rdata_ro = 0xDEADBEEF on the second pulse.
- Byte enables:
  - Stimulus: preload 0x11223344 at addr 0x20; write we = 4'b0101, wdata = 0xAABBCCDD; read addr 0x20.
  - Response: rdata_ro = 0x11BB33DD.
- Wait states, WAIT_STATES = 3:
  - Stimulus: read accepted at edge k.
  - Response: gnt_co = 0 for cycles k+1..k+3; rvalid_ro high only in cycle k+4; a req_i held during WAIT is accepted in the RESP cycle.
- Mid-operation reset, WAIT_STATES = 2:
  - Stimulus: write 0xCAFEF00D to addr 0x8; assert rstn_i = 0 one cycle after acceptance.
  - Response: no rvalid_ro; a later read of 0x8 returns the old contents; all outputs 0 during reset.
- Back-to-back streaming, WAIT_STATES = 0:
  - Stimulus: 8 consecutive reads of addr 0x0..0x1C with req_i held high.
  - Response: 8 consecutive rvalid_ro cycles with data in request order.
- Out-of-range, MEM_WORDS = 1024, JEDRO_1_DATA_RAM_ERR_EN defined:
  - Stimulus: write to addr 0x1000, then read 0x0.
  - Response: err_ro = 1 on the write response; word 0 is unchanged.
  - Without the macro: the same write lands in word 0 (wrap) and err_ro = 0.

Source files
------------

// File: rtl/jedro_1_data_ram.sv
// jedro_1_data_ram: data-memory responder for the jedro_1 core.
// Accepts word-aligned loads/stores with byte enables and answers after
// WAIT_STATES extra cycles with a one-cycle rvalid_ro pulse.
// Optional macro JEDRO_1_DATA_RAM_ERR_EN: flag requests at or above
// MEM_WORDS*4 as errors instead of wrapping them into the array.
module jedro_1_data_ram #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    MEM_WORDS     = 1024,
  parameter int    WAIT_STATES   = 0,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic [3:0]            we_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_co,
  output logic                  rvalid_ro,
  output logic [DATA_WIDTH-1:0] rdata_ro,
  output logic                  err_ro
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [3:0]              r_we;
  logic                    r_oor;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

  logic                    w_accept;
  logic                    w_commit;
  logic                    w_oor_in;
  logic [DATA_WIDTH-1:0]   w_c_addr;
  logic [DATA_WIDTH-1:0]   w_c_wdata;
  logic [3:0]              w_c_we;
  logic                    w_c_oor;
  logic [IDX_W-1:0]        w_c_idx;
  logic                    w_unused;

`ifdef JEDRO_1_DATA_RAM_ERR_EN
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEM_WORDS * 4);
  assign w_oor_in = (addr_i >= ADDR_LIMIT);
`else
  assign w_oor_in = 1'b0;
`endif

  // Grant and next-state decode; the grant is masked while reset is held.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_next = r_state;
    gnt_co = rstn_i && (r_state != S_WAIT);
    unique case (r_state)
      S_IDLE, S_RESP: begin
        if (req_i && gnt_co) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        else                 w_next = S_IDLE;
      end
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = req_i && gnt_co;
  // The array access happens on the edge that enters RESP.
  assign w_commit = (w_next == S_RESP);

  // With no wait states the commit edge is the accepting edge, so the
  // live bus is used; otherwise the latched request is.
  assign w_c_addr  = (WAIT_STATES == 0) ? addr_i   : r_addr;
  assign w_c_wdata = (WAIT_STATES == 0) ? wdata_i  : r_wdata;
  assign w_c_we    = (WAIT_STATES == 0) ? we_i     : r_we;
  assign w_c_oor   = (WAIT_STATES == 0) ? w_oor_in : r_oor;
  assign w_c_idx   = w_c_addr[2 +: IDX_W];

  // Byte-offset and above-array address bits only matter for the range check.
  assign w_unused = ^{w_c_addr[1:0], w_c_addr[DATA_WIDTH-1:IDX_W+2]};

  // State register and wait-state counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)                  r_cnt <= 4'(WAIT_STATES);
      else if (r_state == S_WAIT)    r_cnt <= r_cnt - 4'd1;
    end
  end

  // Latch the request fields at acceptance.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= '0;
      r_oor   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
      r_we    <= we_i;
      r_oor   <= w_oor_in;
    end
  end

  // Response registers: one-cycle valid, load data, error flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalid_ro <= 1'b0;
      rdata_ro  <= '0;
      err_ro    <= 1'b0;
    end else begin
      rvalid_ro <= w_commit;
      err_ro    <= w_commit && w_c_oor;
      if (w_commit && w_c_oor)         rdata_ro <= '0;
      else if (w_commit && w_c_we == 4'b0000) rdata_ro <= r_mem[w_c_idx];
    end
  end

  // Byte-masked array write at the commit edge.
  // NOTE: the storage array has no reset so it maps onto block RAM; reset only gates the commit.
  always_ff @(posedge clk_i) begin
    if (w_commit && !w_c_oor) begin
      for (int n = 0; n < 4; n++) begin
        if (w_c_we[n]) r_mem[w_c_idx][8*n +: 8] <= w_c_wdata[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_jedro_1_data_ram.sv
// Self-checking bench for jedro_1_data_ram. Two instances run side by side:
// index 0 with WAIT_STATES = 0, index 1 with WAIT_STATES = 3.
module tb_jedro_1_data_ram;

  logic        clk;
  logic        rstn   [2];
  logic        req    [2];
  logic [3:0]  we     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word array per instance, plus the last load data seen.
  logic [31:0] m_mem   [2][1024];
  bit          m_known [2][1024];
  logic [31:0] m_rd    [2];

  jedro_1_data_ram #(.WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn[0]), .req_i(req[0]), .we_i(we[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_co(gnt[0]),
    .rvalid_ro(rvalid[0]), .rdata_ro(rdata[0]), .err_ro(err[0]));

  jedro_1_data_ram #(.WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn[1]), .req_i(req[1]), .we_i(we[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_co(gnt[1]),
    .rvalid_ro(rvalid[1]), .rdata_ro(rdata[1]), .err_ro(err[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Spec-level behaviour of one transaction: returns expected rdata/err.
  function automatic void model_txn(input int d, input logic [3:0] w,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] erd, output logic eerr);
    bit oor;
    int idx;
    oor = 1'b0;
`ifdef JEDRO_1_DATA_RAM_ERR_EN
    oor = (a >= 32'h1000);
`endif
    idx = int'((a / 4) % 1024);
    if (oor) m_rd[d] = 32'h0;
    else if (w == 4'b0000) m_rd[d] = m_mem[d][idx];
    else begin
      for (int b = 0; b < 4; b++)
        if (w[b]) m_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
      if (w == 4'hF) m_known[d][idx] = 1'b1;
    end
    erd  = m_rd[d];
    eerr = oor;
  endfunction

  // Drives one request on instance d, returns response latency (-1 on timeout).
  task automatic drive_txn(input int d, input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] wd, output int lat,
                           output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    n = 0;
    while (!gnt[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = -1; rd = 'x; er = 1'bx;
    if (!gnt[d]) begin
      req[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0;
    n = 1;
    while (!rvalid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rvalid[d]) begin
      lat = n; rd = rdata[d]; er = err[d];
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; req[d] = 1'b0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
      m_rd[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (rvalid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid[%0d]: got %b exp 0", d, rvalid[d]); end
      n_checks++; if (rdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h exp 0", d, rdata[d]); end
      n_checks++; if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b exp 0", d, err[d]); end
      n_checks++; if (gnt[d] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt[%0d]: got %b exp 0", d, gnt[d]); end
      rstn[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (gnt[d] !== 1'b1) begin n_fail++; $display("FAIL idle_gnt[%0d]: got %b exp 1", d, gnt[d]); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] erd;
    logic        eer;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    model_txn(0, 4'hF, 32'h10, 32'hDEADBEEF, erd, eer);
    @(negedge clk);
    n_checks++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL wr_rvalid1: got %b exp 1", rvalid[0]); end
    we[0] = 4'h0;
    model_txn(0, 4'h0, 32'h10, 32'h0, erd, eer);
    @(negedge clk);
    req[0] = 1'b0;
    n_checks++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL wr_rvalid2: got %b exp 1", rvalid[0]); end
    n_checks++; if (rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rdata: got %h exp deadbeef", rdata[0]); end
    @(negedge clk);
    n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid_end: got %b exp 0", rvalid[0]); end
  endtask

  task automatic test_byte_enables();
    int lat;
    logic [31:0] rd, erd;
    logic er, eer;
    for (int d = 0; d < 2; d++) begin
      drive_txn(d, 4'hF, 32'h20, 32'h11223344, lat, rd, er);
      model_txn(d, 4'hF, 32'h20, 32'h11223344, erd, eer);
      n_checks++; if (lat != ws_of(d) + 1) begin n_fail++; $display("FAIL be_wr_latency[%0d]: got %0d exp %0d", d, lat, ws_of(d) + 1); end
      drive_txn(d, 4'b0101, 32'h20, 32'hAABBCCDD, lat, rd, er);
      model_txn(d, 4'b0101, 32'h20, 32'hAABBCCDD, erd, eer);
      n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL be_wr_holds_rdata[%0d]: got %h exp %h", d, rd, erd); end
      drive_txn(d, 4'h0, 32'h20, 32'h0, lat, rd, er);
      model_txn(d, 4'h0, 32'h20, 32'h0, erd, eer);
      n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_rdata[%0d]: got %h exp 11bb33dd", d, rd); end
      n_checks++; if (lat != ws_of(d) + 1) begin n_fail++; $display("FAIL be_rd_latency[%0d]: got %0d exp %0d", d, lat, ws_of(d) + 1); end
    end
  endtask

  task automatic test_wait_states();
    int lat;
    logic [31:0] rd, erd_a, erd_b;
    logic er, eer;
    drive_txn(1, 4'hF, 32'h30, 32'h0BADF00D, lat, rd, er);
    model_txn(1, 4'hF, 32'h30, 32'h0BADF00D, erd_a, eer);
    drive_txn(1, 4'hF, 32'h34, 32'h600DCAFE, lat, rd, er);
    model_txn(1, 4'hF, 32'h34, 32'h600DCAFE, erd_a, eer);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 4'h0; addr[1] = 32'h30;
    model_txn(1, 4'h0, 32'h30, 32'h0, erd_a, eer);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) addr[1] = 32'h34;
      n_checks++; if (gnt[1] !== 1'b0) begin n_fail++; $display("FAIL ws_gnt_k%0d: got %b exp 0", k, gnt[1]); end
      n_checks++; if (rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL ws_rvalid_k%0d: got %b exp 0", k, rvalid[1]); end
    end
    @(negedge clk);
    n_checks++; if (rvalid[1] !== 1'b1) begin n_fail++; $display("FAIL ws_rvalid_k4: got %b exp 1", rvalid[1]); end
    n_checks++; if (rdata[1] !== erd_a) begin n_fail++; $display("FAIL ws_rdata_a: got %h exp %h", rdata[1], erd_a); end
    n_checks++; if (gnt[1] !== 1'b1) begin n_fail++; $display("FAIL ws_gnt_resp: got %b exp 1", gnt[1]); end
    model_txn(1, 4'h0, 32'h34, 32'h0, erd_b, eer);
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      n_checks++; if (rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL ws_b2b_rvalid_k%0d: got %b exp 0", k, rvalid[1]); end
      @(negedge clk);
    end
    n_checks++; if (rvalid[1] !== 1'b1) begin n_fail++; $display("FAIL ws_b2b_rvalid_k8: got %b exp 1", rvalid[1]); end
    n_checks++; if (rdata[1] !== erd_b) begin n_fail++; $display("FAIL ws_rdata_b: got %h exp %h", rdata[1], erd_b); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd, erd;
    logic er, eer;
    logic [31:0] exp_q [$];
    for (int i = 0; i < 8; i++) begin
      rd = $urandom;
      drive_txn(0, 4'hF, 32'(4 * i), rd, lat, erd, er);
      model_txn(0, 4'hF, 32'(4 * i), rd, erd, eer);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 8) begin
        n_checks++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid_%0d: got %b exp 1", c - 1, rvalid[0]); end
        erd = exp_q.pop_front();
        n_checks++; if (rdata[0] !== erd) begin n_fail++; $display("FAIL b2b_rdata_%0d: got %h exp %h", c - 1, rdata[0], erd); end
      end
      if (c == 9) begin
        n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_end: got %b exp 0", rvalid[0]); end
      end
      if (c < 8) begin
        n_checks++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt_%0d: got %b exp 1", c, gnt[0]); end
        req[0] = 1'b1; we[0] = 4'h0; addr[0] = 32'(4 * c);
        model_txn(0, 4'h0, 32'(4 * c), 32'h0, erd, eer);
        exp_q.push_back(erd);
      end else begin
        req[0] = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    logic [31:0] rd, erd;
    logic er, eer;
    drive_txn(1, 4'hF, 32'h8, 32'h5A5A1234, lat, rd, er);
    model_txn(1, 4'hF, 32'h8, 32'h5A5A1234, erd, eer);
    drive_txn(1, 4'h0, 32'h8, 32'h0, lat, rd, er);
    model_txn(1, 4'h0, 32'h8, 32'h0, erd, eer);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 4'hF; addr[1] = 32'h8; wdata[1] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    rstn[1] = 1'b0;
    #1;
    n_checks++; if (rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL mr_rvalid: got %b exp 0", rvalid[1]); end
    n_checks++; if (rdata[1] !== 32'h0) begin n_fail++; $display("FAIL mr_rdata: got %h exp 0", rdata[1]); end
    n_checks++; if (err[1] !== 1'b0) begin n_fail++; $display("FAIL mr_err: got %b exp 0", err[1]); end
    n_checks++; if (gnt[1] !== 1'b0) begin n_fail++; $display("FAIL mr_gnt: got %b exp 0", gnt[1]); end
    m_rd[1] = 32'h0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rvalid[1]) seen++;
    end
    rstn[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rvalid[1]) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mr_no_rvalid: got %0d pulses exp 0", seen); end
    drive_txn(1, 4'h0, 32'h8, 32'h0, lat, rd, er);
    model_txn(1, 4'h0, 32'h8, 32'h0, erd, eer);
    n_checks++; if (rd !== 32'h5A5A1234) begin n_fail++; $display("FAIL mr_old_data: got %h exp 5a5a1234", rd); end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [31:0] rd, erd;
    logic er, eer;
    drive_txn(0, 4'hF, 32'h0, 32'h01020304, lat, rd, er);
    model_txn(0, 4'hF, 32'h0, 32'h01020304, erd, eer);
    drive_txn(0, 4'hF, 32'h1000, 32'hFFFF0000, lat, rd, er);
    model_txn(0, 4'hF, 32'h1000, 32'hFFFF0000, erd, eer);
    n_checks++; if (er !== eer) begin n_fail++; $display("FAIL oor_err: got %b exp %b", er, eer); end
    n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL oor_rdata: got %h exp %h", rd, erd); end
    @(negedge clk);
    n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear: got %b exp 0", err[0]); end
    drive_txn(0, 4'h0, 32'h0, 32'h0, lat, rd, er);
    model_txn(0, 4'h0, 32'h0, 32'h0, erd, eer);
    n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL oor_word0: got %h exp %h", rd, erd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL oor_read_err: got %b exp 0", er); end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a, wd, rd, erd;
    logic [3:0] w;
    logic er, eer;
    int idx;
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 40; t++) begin
        idx = $urandom_range(0, 63);
        a = 32'(idx * 4) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
        wd = $urandom;
        if (!m_known[d][idx]) w = 4'hF;
        else if ($urandom_range(0, 1) == 0) w = 4'h0;
        else w = 4'($urandom_range(1, 15));
        drive_txn(d, w, a, wd, lat, rd, er);
        model_txn(d, w, a, wd, erd, eer);
        n_checks++; if (lat != ws_of(d) + 1) begin n_fail++; $display("FAIL rnd_latency[%0d] t%0d: got %0d exp %0d", d, t, lat, ws_of(d) + 1); end
        n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL rnd_rdata[%0d] t%0d: we %h addr %h got %h exp %h", d, t, w, a, rd, erd); end
        n_checks++; if (er !== eer) begin n_fail++; $display("FAIL rnd_err[%0d] t%0d: got %b exp %b", d, t, er, eer); end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) m_known[d][i] = 1'b0;
    test_reset();
    test_write_read();
    test_byte_enables();
    test_wait_states();
    test_back_to_back();
    test_mid_reset();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
